trace_capture_ctrl: RTL and testbench
=====================================

Name: trace_capture_ctrl

Overview:
- Capture sequencer for the on-chip logic-analyzer datapath.
- Qualifies trigger samples against a masked compare value and writes trace samples into a circular trace RAM.
- Holds pre-trigger history, counts a programmable number of post-trigger samples, then freezes and reports the trigger address for JTAG readback.
- Sits between the debug core's trigger/trace inputs and the trace buffer RAM.

Parameters:
- TRIG_W, 6, width of the trigger input bus.
- TRACE_W, 6, width of the trace sample bus.
- ADDR_W, 6, trace buffer address width; DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  sample clock
- reset  in  1  asynchronous active-high reset
- arm  in  1  start-capture pulse
- abort  in  1  return-to-idle pulse
- sample_en  in  1  sample qualifier; a sample is taken only on cycles where this is 1
- trigger_en  in  1  global trigger enable; match ignored when 0
- trig_din  in  TRIG_W  trigger data
- trig_value  in  TRIG_W  compare value, latched at arm
- trig_mask  in  TRIG_W  1 = bit compared, latched at arm
- post_count  in  ADDR_W  samples to capture after the trigger sample, latched at arm
- trace_din  in  TRACE_W  trace data
- buf_we  out  1  trace RAM write enable
- buf_waddr  out  ADDR_W  trace RAM write address
- buf_wdata  out  TRACE_W  trace RAM write data
- armed  out  1  state is ARMED
- triggered  out  1  state is POST or DONE
- done  out  1  state is DONE
- trig_addr  out  ADDR_W  buffer address holding the trigger sample
- wrapped  out  1  pre-trigger write pointer has wrapped at least once

Behaviour:
- States: IDLE, ARMED, POST, DONE. On reset: state IDLE; all outputs 0; internal write pointer wptr = 0.
- All outputs are registered. The buf_* outputs carry the sample taken in the previous cycle (1-cycle latency).
- IDLE/DONE + arm:
  - Latch trig_value, trig_mask, post_count.
  - Clear wptr, wrapped, trig_addr.
  - Next state ARMED. No sample is taken in the arm cycle.
- arm in ARMED or POST is ignored. abort has priority over arm and over match in the same cycle.
- abort in any state: next state IDLE, buf_we 0 next cycle. Latched config, trig_addr and wrapped are retained.
- ARMED, sample_en = 1:
  - Write the sample: buf_we = 1, buf_waddr = wptr, buf_wdata = trace_din; then wptr = wptr + 1 mod DEPTH.
  - wrapped set when wptr goes from DEPTH-1 to 0.
  - match = trigger_en & ((trig_din ^ value_l) & mask_l) == 0. An all-zero mask matches the first qualified sample.
  - On match, the matching sample is still written and trig_addr = that sample's address:
    - If post_count_l == 0: next state DONE.
    - Else: remaining = post_count_l, next state POST.
- POST, sample_en = 1: write as in ARMED, remaining = remaining - 1. When remaining reaches 0 after this write, next state DONE. Further trigger matches are ignored.
- sample_en = 0 in any state: no write (buf_we = 0), no counter change, no match evaluated.
- DONE: no writes, status held until arm, abort or reset.
- post_count maximum is DEPTH-1, so the trigger sample is never overwritten.
- Reset asserted mid-capture: immediate IDLE with all outputs 0; no partial write completes.

Test Plan:
- Basic capture:
  - Setup: mask = 0x3F, value = 0x05, post_count = 3, trig_din = incrementing counter starting at 0, sample_en = 1.
  - Required: trigger at the sample 0x05, trig_addr = 5, writes to addresses 0..8, done asserted 1 cycle after the write to address 8, then buf_we = 0.
- Wrap:
  - Setup: value = 0x3F, mask = 0x3F, counter starting at 0, post_count = 2, DEPTH = 64.
  - Required: trigger at sample 63, trig_addr = 63, wrapped = 0. Post writes go to addresses 0 and 1. done asserted.
- Masked and edge cases:
  - Mask = 0: trigger on the first qualified sample, trig_addr = 0.
  - post_count = 0: DONE directly after the trigger write; exactly one write at trig_addr.
- Qualifiers:
  - trigger_en = 0 while the data matches: no trigger, writes continue.
  - sample_en toggling 1/0: writes and counters advance only on the 1 cycles; post length counts qualified samples only.
- Abort and arm interaction:
  - abort in POST: IDLE next cycle, buf_we = 0.
  - abort and arm in the same cycle from DONE: stays IDLE.
  - arm during ARMED: no effect; wptr is not reset.
- Reset mid-POST:
  - Assert reset asynchronously.
  - Required: all outputs 0 immediately; after reset release, a new arm works normally.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// trace_capture_ctrl: trigger-qualified circular trace capture with post-trigger count and freeze
module trace_capture_ctrl #(
    parameter int TRIG_W  = 6,
    parameter int TRACE_W = 6,
    parameter int ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic               sample_en,
    input  logic               trigger_en,
    input  logic [TRIG_W-1:0]  trig_din,
    input  logic [TRIG_W-1:0]  trig_value,
    input  logic [TRIG_W-1:0]  trig_mask,
    input  logic [ADDR_W-1:0]  post_count,
    input  logic [TRACE_W-1:0] trace_din,
    output logic               buf_we,
    output logic [ADDR_W-1:0]  buf_waddr,
    output logic [TRACE_W-1:0] buf_wdata,
    output logic               armed,
    output logic               triggered,
    output logic               done,
    output logic [ADDR_W-1:0]  trig_addr,
    output logic               wrapped
);
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
    state_t state, state_n;
    logic [TRIG_W-1:0] value_l, mask_l;
    logic [ADDR_W-1:0] post_l, remaining, wptr;
    logic take, match, arm_go;
    assign take   = sample_en && !abort && (state == ARMED || state == POST);
    assign arm_go = arm && !abort && (state == IDLE || state == DONE);
    assign match  = trigger_en && (((trig_din ^ value_l) & mask_l) == '0);
    always_comb begin
        state_n = state;
        if (abort)
            state_n = IDLE;
        else if (arm_go)
            state_n = ARMED;
        else if (take && state == ARMED && match)
            state_n = (post_l == '0) ? DONE : POST;
        else if (take && state == POST && remaining == ADDR_W'(1))
            state_n = DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            value_l   <= '0;
            mask_l    <= '0;
            post_l    <= '0;
            remaining <= '0;
            wptr      <= '0;
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            trig_addr <= '0;
            wrapped   <= 1'b0;
        end else begin
            state  <= state_n;
            buf_we <= take;
            if (arm_go) begin
                value_l   <= trig_value;
                mask_l    <= trig_mask;
                post_l    <= post_count;
                wptr      <= '0;
                wrapped   <= 1'b0;
                trig_addr <= '0;
            end
            if (take) begin
                buf_waddr <= wptr;
                buf_wdata <= trace_din;
                wptr      <= wptr + 1'b1;
            end
            // only pre-trigger writes count toward wrapped; the trigger sample itself does not
            if (take && state == ARMED) begin
                if (match) begin
                    trig_addr <= wptr;
                    remaining <= post_l;
                end else if (&wptr) begin
                    wrapped <= 1'b1;
                end
            end
            if (take && state == POST)
                remaining <= remaining - 1'b1;
        end
    end
    assign armed     = (state == ARMED);
    assign triggered = (state == POST) || (state == DONE);
    assign done      = (state == DONE);
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb_trace_capture_ctrl: scoreboard bench for trace_capture_ctrl
module tb_trace_capture_ctrl;
    logic       clk = 0, reset = 1, arm = 0, abort = 0, sample_en = 0, trigger_en = 1;
    logic [5:0] trig_din = 0, trig_value = 0, trig_mask = 0, post_count = 0, trace_din = 0;
    logic       buf_we, armed, triggered, done, wrapped;
    logic [5:0] buf_waddr, buf_wdata, trig_addr;
    logic [11:0] q[$];
    logic [5:0]  ea;
    int checks = 0, errors = 0;

    trace_capture_ctrl dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .sample_en(sample_en),
        .trigger_en(trigger_en), .trig_din(trig_din), .trig_value(trig_value),
        .trig_mask(trig_mask), .post_count(post_count), .trace_din(trace_din),
        .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .armed(armed),
        .triggered(triggered), .done(done), .trig_addr(trig_addr), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // every observed write must match the oldest expected {addr,data}
    always @(negedge clk) begin
        if (buf_we) begin
            if (q.size() == 0) check("unexp_we", 1, 0);
            else begin
                logic [11:0] e;
                e = q.pop_front();
                check("waddr", buf_waddr, e[11:6]);
                check("wdata", buf_wdata, e[5:0]);
            end
        end
    end

    task automatic do_arm(input logic [5:0] v, input logic [5:0] m, input logic [5:0] pc);
        arm = 1; trig_value = v; trig_mask = m; post_count = pc; ea = 0;
        @(posedge clk); #1;
        arm = 0;
        check("armed", armed, 1);
    endtask

    task automatic sample(input logic [5:0] d, input logic en, input logic w);
        sample_en = en; trig_din = d; trace_din = d ^ 6'h2A;
        if (w) begin
            q.push_back({ea, d ^ 6'h2A});
            ea++;
        end
        @(posedge clk); #1;
        sample_en = 0;
    endtask

    task automatic finish_test(input string tag);
        @(negedge clk); #1;
        check(tag, q.size(), 0);
    endtask

    initial begin
        @(posedge clk); @(posedge clk); #1;
        check("rst_we", buf_we, 0);
        check("rst_armed", armed, 0);
        check("rst_done", done, 0);
        check("rst_taddr", trig_addr, 0);
        reset = 0;
        @(posedge clk); #1;

        // basic capture: trigger on 5, three post samples
        do_arm(6'h05, 6'h3F, 6'd3);
        for (int i = 0; i < 9; i++) begin
            sample(6'(i), 1, 1);
            if (i == 4) check("b_trig_early", triggered, 0);
            if (i == 5) check("b_taddr", trig_addr, 5);
            if (i == 7) check("b_done_early", done, 0);
        end
        check("b_done", done, 1);
        sample(6'd9, 1, 0);
        check("b_we_after", buf_we, 0);
        finish_test("b_q");

        // wrap: trigger on the 64th sample, post writes land at 0 and 1
        do_arm(6'h3F, 6'h3F, 6'd2);
        for (int i = 0; i < 64; i++) sample(6'(i), 1, 1);
        check("w_taddr", trig_addr, 63);
        check("w_wrapped", wrapped, 0);
        check("w_trig", triggered, 1);
        sample(6'd0, 1, 1);
        check("w_done_early", done, 0);
        sample(6'd1, 1, 1);
        check("w_done", done, 1);
        finish_test("w_q");

        // zero mask with sample_en toggling; post length counts qualified samples
        do_arm(6'h15, 6'h00, 6'd2);
        sample(6'd7, 0, 0);
        check("m_no_trig", triggered, 0);
        sample(6'd7, 1, 1);
        check("m_taddr", trig_addr, 0);
        check("m_trig", triggered, 1);
        sample(6'd8, 0, 0);
        check("m_we_off", buf_we, 0);
        sample(6'd9, 1, 1);
        check("m_done_early", done, 0);
        sample(6'd9, 0, 0);
        sample(6'd10, 1, 1);
        check("m_done", done, 1);
        finish_test("m_q");

        // post_count 0: single trigger write then frozen
        do_arm(6'h09, 6'h3F, 6'd0);
        sample(6'd7, 1, 1);
        sample(6'd8, 1, 1);
        sample(6'd9, 1, 1);
        check("p0_done", done, 1);
        check("p0_taddr", trig_addr, 2);
        sample(6'd10, 1, 0);
        check("p0_we", buf_we, 0);
        finish_test("p0_q");
        abort = 1; arm = 1;
        @(posedge clk); #1;
        abort = 0; arm = 0;
        check("aa_done", done, 0);
        check("aa_armed", armed, 0);
        check("aa_taddr", trig_addr, 2);

        // trigger_en gating, ignored re-arm, abort in POST
        trigger_en = 0;
        do_arm(6'h03, 6'h3F, 6'd4);
        sample(6'd3, 1, 1);
        sample(6'd3, 1, 1);
        check("te_trig", triggered, 0);
        trigger_en = 1;
        arm = 1; trig_value = 6'h10; post_count = 6'd0;
        @(posedge clk); #1;
        arm = 0;
        check("ra_armed", armed, 1);
        sample(6'd3, 1, 1);
        check("ra_taddr", trig_addr, 2);
        check("ra_trig", triggered, 1);
        sample(6'd4, 1, 1);
        check("ra_done", done, 0);
        abort = 1; sample_en = 1;
        @(posedge clk); #1;
        abort = 0; sample_en = 0;
        check("ab_we", buf_we, 0);
        check("ab_trig", triggered, 0);
        check("ab_armed", armed, 0);
        finish_test("ab_q");

        // asynchronous reset mid-POST, then a fresh capture
        do_arm(6'h02, 6'h3F, 6'd5);
        for (int i = 0; i < 4; i++) sample(6'(i), 1, 1);
        check("r_taddr_pre", trig_addr, 2);
        @(negedge clk); #1;
        reset = 1; #1;
        check("r_we", buf_we, 0);
        check("r_waddr", buf_waddr, 0);
        check("r_wdata", buf_wdata, 0);
        check("r_taddr", trig_addr, 0);
        check("r_trig", triggered, 0);
        check("r_q", q.size(), 0);
        @(posedge clk); #1;
        reset = 0;
        do_arm(6'h01, 6'h3F, 6'd1);
        for (int i = 0; i < 3; i++) sample(6'(i), 1, 1);
        check("r2_taddr", trig_addr, 1);
        check("r2_done", done, 1);
        finish_test("r2_q");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
